max_pool_2x2_ctrl: RTL

- 2x2 stride-2 max-pooling engine between the conv-result image memory (upstream, 4-tap registered read) and the pooled-result memory (downstream, write port wen/wadd/data_in).
- On start, scans all channels of an n_r x n_c signed feature map, reads each 2x2 window in one read, takes the signed maximum, and writes one pooled word per window.
- Default dimensions: 26x26x3 in, 13x13x3 = 507 words out.

---
 rtl/cnn_pool_pkg.sv | 20 ++
 rtl/max4_signed.sv | 30 +++
 rtl/max_pool_2x2_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cnn_pool_pkg.sv
// Shared definitions for the 2x2 max-pooling controller: FSM state encoding,
// default feature-map dimensions and pixel width.
package cnn_pool_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      CMP   = 3'd3,
      WRITE = 3'd4,
      FIN   = 3'd5
   } pool_state_t;

   localparam int DEF_N_C    = 26;
   localparam int DEF_N_R    = 26;
   localparam int DEF_N_CH   = 3;
   localparam int DEF_N_POOL = 13;
   localparam int PIXEL_W    = 8;

endpackage

// File: rtl/max4_signed.sv
// Combinational signed maximum of four pixels.
// With POOL_RELU_EN defined, negative results are clamped to zero (fused ReLU).
module max4_signed
   import cnn_pool_pkg::*;
#(
   parameter int dataWidth = PIXEL_W
) (
   input  logic signed [dataWidth-1:0] d0,
   input  logic signed [dataWidth-1:0] d1,
   input  logic signed [dataWidth-1:0] d2,
   input  logic signed [dataWidth-1:0] d3,
   output logic signed [dataWidth-1:0] max_val
);

   logic signed [dataWidth-1:0] m01;
   logic signed [dataWidth-1:0] m23;
   logic signed [dataWidth-1:0] m_all;

   always_comb begin
      m01   = (d0 > d1) ? d0 : d1;
      m23   = (d2 > d3) ? d2 : d3;
      m_all = (m01 > m23) ? m01 : m23;
`ifdef POOL_RELU_EN
      max_val = m_all[dataWidth-1] ? '0 : m_all;
`else
      max_val = m_all;
`endif
   end

endmodule

// File: rtl/max_pool_2x2_ctrl.sv
// 2x2 stride-2 max-pooling sequencer: one upstream 4-tap read and one pooled
// write per window, four cycles per window. Optional ReLU via POOL_RELU_EN.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | ren high, window address on radd1/radd2
// WAIT  | upstream registers the four taps; max captured at end of cycle
// CMP   | pooled value held, write strobe armed
// WRITE | wen high for one cycle; advance window or finish
// FIN   | done pulse, busy low
module max_pool_2x2_ctrl
   import cnn_pool_pkg::*;
#(
   parameter int n_c                  = DEF_N_C,
   parameter int n_r                  = DEF_N_R,
   parameter int n_ch                 = DEF_N_CH,
   parameter int dataWidth            = PIXEL_W,
   parameter int rowAddrWidth         = 7,
   parameter int colAddrWidth         = 5,
   parameter int addressWidthRstlConv = 10
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   ren,
   output logic        [rowAddrWidth-1:0]         radd1,
   output logic        [colAddrWidth-1:0]         radd2,
   input  logic signed [dataWidth-1:0]            rdata0,
   input  logic signed [dataWidth-1:0]            rdata1,
   input  logic signed [dataWidth-1:0]            rdata2,
   input  logic signed [dataWidth-1:0]            rdata3,
   output logic                                   wen,
   output logic        [addressWidthRstlConv-1:0] wadd,
   output logic signed [dataWidth-1:0]            data_out
);

   localparam int N_WC = n_c / 2;
   localparam int N_WR = n_r / 2;
   localparam int C_W  = (N_WC > 1) ? $clog2(N_WC) : 1;
   localparam int R_W  = (N_WR > 1) ? $clog2(N_WR) : 1;
   localparam int CH_W = (n_ch > 1) ? $clog2(n_ch) : 1;

   pool_state_t state;

   logic [C_W-1:0]          c_cnt, c_nxt;
   logic [R_W-1:0]          r_cnt, r_nxt;
   logic [CH_W-1:0]         ch_cnt, ch_nxt;
   logic [rowAddrWidth-1:0] row_base, base_nxt;
   logic [rowAddrWidth-1:0] radd1_nxt;
   logic [colAddrWidth-1:0] radd2_nxt;
   logic                    last_c, last_r, last_ch, last_win;
   logic signed [dataWidth-1:0] max_val;

   max4_signed #(.dataWidth(dataWidth)) u_max4 (
      .d0      (rdata0),
      .d1      (rdata1),
      .d2      (rdata2),
      .d3      (rdata3),
      .max_val (max_val)
   );

   assign last_c   = (c_cnt == C_W'(N_WC - 1));
   assign last_r   = (r_cnt == R_W'(N_WR - 1));
   assign last_ch  = (ch_cnt == CH_W'(n_ch - 1));
   assign last_win = last_c && last_r && last_ch;

   // row_base tracks ch*n_r so the stacked row address needs no multiplier
   always_comb begin
      c_nxt    = c_cnt + 1'b1;
      r_nxt    = r_cnt;
      ch_nxt   = ch_cnt;
      base_nxt = row_base;
      if (last_c) begin
         c_nxt = '0;
         r_nxt = r_cnt + 1'b1;
         if (last_r) begin
            r_nxt    = '0;
            ch_nxt   = ch_cnt + 1'b1;
            base_nxt = row_base + rowAddrWidth'(n_r);
         end
      end
      radd1_nxt = base_nxt + rowAddrWidth'({r_nxt, 1'b0});
      radd2_nxt = colAddrWidth'({c_nxt, 1'b0});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         ren      <= 1'b0;
         wen      <= 1'b0;
         radd1    <= '0;
         radd2    <= '0;
         wadd     <= '0;
         data_out <= '0;
         c_cnt    <= '0;
         r_cnt    <= '0;
         ch_cnt   <= '0;
         row_base <= '0;
      end else begin
         done <= 1'b0;
         ren  <= 1'b0;
         wen  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  c_cnt    <= '0;
                  r_cnt    <= '0;
                  ch_cnt   <= '0;
                  row_base <= '0;
                  radd1    <= '0;
                  radd2    <= '0;
                  wadd     <= '0;
                  busy     <= 1'b1;
                  ren      <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: state <= WAIT;
            // taps are guaranteed valid only in the cycle after ren
            WAIT: begin
               data_out <= max_val;
               state    <= CMP;
            end
            CMP: begin
               wen   <= 1'b1;
               state <= WRITE;
            end
            WRITE: begin
               if (last_win) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= FIN;
               end else begin
                  c_cnt    <= c_nxt;
                  r_cnt    <= r_nxt;
                  ch_cnt   <= ch_nxt;
                  row_base <= base_nxt;
                  radd1    <= radd1_nxt;
                  radd2    <= radd2_nxt;
                  wadd     <= wadd + 1'b1;
                  ren      <= 1'b1;
                  state    <= ISSUE;
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
